hash_match_collector: RTL and testbench

Downstream consumer of the initial-hash pipeline. Each cycle it compares the pipeline's 32-bit hash against a masked target and captures every hit, together with the delay-aligned 56-bit candidate string, into a small FIFO. Hits are drained to the host/UART side through a valid/ready handshake. It also tracks drops and run state so a search can be started, stopped and drained cleanly.

---
 rtl/hash_cracker_pkg.sv | 29 ++
 rtl/hit_fifo.sv | 60 ++++++
 rtl/hash_match_collector.sv | 152 +++++++++++++++
 tb/tb_hash_match_collector.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/hash_cracker_pkg.sv
// rtl/hash_cracker_pkg.sv - shared types and widths for the hash cracker datapath
package hash_cracker_pkg;

    localparam int HASH_W    = 32;
    localparam int CHAR_W    = 7;
    localparam int NUM_CHARS = 8;
    localparam int STR_W     = CHAR_W * NUM_CHARS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [HASH_W-1:0] hash;
        logic [STR_W-1:0]  str;
    } hit_entry_t;

    // A set mask bit means that hash bit must equal the target bit.
    function automatic logic hash_match(
        input logic [HASH_W-1:0] hash,
        input logic [HASH_W-1:0] target,
        input logic [HASH_W-1:0] mask
    );
        return ((hash ^ target) & mask) == '0;
    endfunction

endpackage

// File: rtl/hit_fifo.sv
// rtl/hit_fifo.sv - synchronous FIFO of hit entries with write-through-when-full on pop
module hit_fifo
    import hash_cracker_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_wr,
    input  hit_entry_t i_wr_data,
    input  logic       i_rd,
    output hit_entry_t o_rd_data,
    output logic       o_full,
    output logic       o_empty,
    output logic       o_drop
);

    localparam int AW = $clog2(FIFO_DEPTH);

    hit_entry_t        r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              w_rd;
    logic              w_wr;

    assign o_full    = (r_count == (AW+1)'(FIFO_DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_rd      = i_rd && !o_empty;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the write.
    assign w_wr      = i_wr && (!o_full || w_rd);
    assign o_drop    = i_wr && o_full && !w_rd;
    assign o_rd_data = r_mem[r_rd_ptr];

    // Storage and pointer/occupancy update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= i_wr_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/hash_match_collector.sv
// rtl/hash_match_collector.sv - masked hash compare, hit FIFO and run control (stats: HASH_MATCH_STATS_EN)
module hash_match_collector
    import hash_cracker_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              cfg_we,
    input  logic [HASH_W-1:0] cfg_target,
    input  logic [HASH_W-1:0] cfg_mask,
    input  logic              in_valid,
    input  logic [HASH_W-1:0] in_hash,
    input  logic [STR_W-1:0]  in_str,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [HASH_W-1:0] out_hash,
    output logic [STR_W-1:0]  out_str,
    output logic              busy,
    output logic              overflow,
    output logic [31:0]       hit_count,
    output logic [15:0]       drop_count
);

    state_t            r_state;
    logic [HASH_W-1:0] r_target;
    logic [HASH_W-1:0] r_mask;
    logic              r_cmp_hit;
    hit_entry_t        r_cmp_entry;
    logic              r_overflow;

    logic              w_start_go;
    logic              w_fifo_empty;
    logic              w_fifo_full;
    logic              w_drop;
    logic              w_pop;
    hit_entry_t        w_head;

    assign w_start_go = (r_state == ST_IDLE) && start;
    assign w_pop      = out_valid && out_ready;

    assign out_valid  = !w_fifo_empty;
    assign out_hash   = w_head.hash;
    assign out_str    = w_head.str;
    assign busy       = (r_state != ST_IDLE);
    assign overflow   = r_overflow;

    // Run-control state machine; target/mask only writable while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_target <= '0;
            r_mask   <= '1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cfg_we) begin
                        r_target <= cfg_target;
                        r_mask   <= cfg_mask;
                    end
                    if (start) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!r_cmp_hit && w_fifo_empty) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Compare stage: only inputs seen while running can register a hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmp_hit   <= 1'b0;
            r_cmp_entry <= '0;
        end else begin
            if ((r_state == ST_RUN) && in_valid && hash_match(in_hash, r_target, r_mask)) begin
                r_cmp_hit        <= 1'b1;
                r_cmp_entry.hash <= in_hash;
                r_cmp_entry.str  <= in_str;
            end else begin
                r_cmp_hit <= 1'b0;
            end
        end
    end

    // Sticky drop flag, cleared when a new search starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_start_go) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

`ifdef HASH_MATCH_STATS_EN
    logic [31:0] r_hit_count;
    logic [15:0] r_drop_count;

    // Saturating hit/drop statistics, cleared when a new search starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_count  <= '0;
            r_drop_count <= '0;
        end else if (w_start_go) begin
            r_hit_count  <= '0;
            r_drop_count <= '0;
        end else begin
            if (r_cmp_hit && (r_hit_count != '1)) begin
                r_hit_count <= r_hit_count + 1'b1;
            end
            if (w_drop && (r_drop_count != '1)) begin
                r_drop_count <= r_drop_count + 1'b1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign drop_count = r_drop_count;
`else
    assign hit_count  = '0;
    assign drop_count = '0;
`endif

    hit_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_hit_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr      (r_cmp_hit),
        .i_wr_data (r_cmp_entry),
        .i_rd      (w_pop),
        .o_rd_data (w_head),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty),
        .o_drop    (w_drop)
    );

endmodule

// File: tb/tb_hash_match_collector.sv
// tb/tb_hash_match_collector.sv - directed self-checking bench for hash_match_collector
module tb_hash_match_collector;

`ifdef HASH_MATCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        cfg_we = 1'b0;
    logic [31:0] cfg_target = '0;
    logic [31:0] cfg_mask = '0;
    logic        in_valid = 1'b0;
    logic [31:0] in_hash = '0;
    logic [55:0] in_str = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_hash;
    logic [55:0] out_str;
    logic        busy;
    logic        overflow;
    logic [31:0] hit_count;
    logic [15:0] drop_count;

    int n_checks = 0;
    int n_errors = 0;

    hash_match_collector #(.FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .cfg_we     (cfg_we),
        .cfg_target (cfg_target),
        .cfg_mask   (cfg_mask),
        .in_valid   (in_valid),
        .in_hash    (in_hash),
        .in_str     (in_str),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_hash   (out_hash),
        .out_str    (out_str),
        .busy       (busy),
        .overflow   (overflow),
        .hit_count  (hit_count),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] st(input int n);
        return STATS ? 64'(n) : 64'd0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] h, input logic [55:0] s);
        in_valid = 1'b1;
        in_hash  = h;
        in_str   = s;
        step();
        in_valid = 1'b0;
    endtask

    task automatic cfg(input logic [31:0] t, input logic [31:0] m);
        cfg_we     = 1'b1;
        cfg_target = t;
        cfg_mask   = m;
        step();
        cfg_we     = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic halt_to_idle();
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();
        step();
    endtask

    task automatic pop_check(input string tag, input logic [31:0] eh, input logic [55:0] es);
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_hash"}, 64'(out_hash), 64'(eh));
        chk({tag, "_str"}, 64'(out_str), 64'(es));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_out_hash", 64'(out_hash), 64'd0);
        chk("rst_out_str", 64'(out_str), 64'd0);
        chk("rst_hit_count", 64'(hit_count), 64'd0);
        chk("rst_drop_count", 64'(drop_count), 64'd0);
        step();
        rst_n = 1'b1;
        step();

        // Exact match, latency 2
        cfg(32'h1234_5678, 32'hFFFF_FFFF);
        go();
        chk("t1_busy", 64'(busy), 64'd1);
        send(32'h1234_5678, 56'h00_0041_4243_4445);
        chk("t1_lat1_valid", 64'(out_valid), 64'd0);
        step();
        chk("t1_hit_count", 64'(hit_count), st(1));
        pop_check("t1_pop", 32'h1234_5678, 56'h00_0041_4243_4445);
        chk("t1_empty", 64'(out_valid), 64'd0);
        halt_to_idle();
        chk("t1_idle", 64'(busy), 64'd0);

        // Partial mask
        cfg(32'h0000_0078, 32'h0000_00FF);
        go();
        send(32'hAAAA_AA78, 56'h11);
        send(32'hAAAA_AA79, 56'h22);
        step();
        step();
        chk("t2_hit_count", 64'(hit_count), st(1));
        pop_check("t2_pop", 32'hAAAA_AA78, 56'h11);
        chk("t2_empty", 64'(out_valid), 64'd0);

        // Overflow: 6 hits into depth 4, no reads
        for (int i = 0; i < 6; i++) begin
            send(32'h78 | (32'(i) << 8), 56'(i));
        end
        step();
        step();
        chk("t3_overflow", 64'(overflow), 64'd1);
        chk("t3_drop_count", 64'(drop_count), st(2));
        chk("t3_hit_count", 64'(hit_count), st(7));
        for (int i = 0; i < 4; i++) begin
            pop_check("t3_pop", 32'h78 | (32'(i) << 8), 56'(i));
        end
        chk("t3_empty", 64'(out_valid), 64'd0);
        halt_to_idle();
        chk("t3_idle", 64'(busy), 64'd0);
        go();
        chk("t3_restart_overflow", 64'(overflow), 64'd0);
        chk("t3_restart_hits", 64'(hit_count), 64'd0);

        // Full FIFO with simultaneous pop and write
        for (int i = 0; i < 5; i++) begin
            send(32'h78 | (32'(16 + i) << 8), 56'(16 + i));
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t4_overflow", 64'(overflow), 64'd0);
        chk("t4_drop_count", 64'(drop_count), 64'd0);
        chk("t4_hit_count", 64'(hit_count), st(5));
        for (int i = 1; i < 5; i++) begin
            pop_check("t4_pop", 32'h78 | (32'(16 + i) << 8), 56'(16 + i));
        end
        chk("t4_empty", 64'(out_valid), 64'd0);

        // cfg_we ignored in RUN; stop with queued hits; DRAIN inputs discarded
        cfg(32'h0, 32'h0);
        send(32'h0000_0001, 56'h0);
        step();
        step();
        chk("t5_cfg_ignored", 64'(out_valid), 64'd0);
        send(32'h578, 56'h5);
        send(32'h678, 56'h6);
        in_valid = 1'b1;
        in_hash  = 32'h778;
        in_str   = 56'h7;
        stop     = 1'b1;
        step();
        stop     = 1'b0;
        in_valid = 1'b0;
        send(32'h878, 56'h8);
        step();
        step();
        chk("t5_drain_busy", 64'(busy), 64'd1);
        pop_check("t5_pop1", 32'h578, 56'h5);
        pop_check("t5_pop2", 32'h678, 56'h6);
        chk("t5_busy_before_last", 64'(busy), 64'd1);
        pop_check("t5_pop3", 32'h778, 56'h7);
        chk("t5_no_drain_hit", 64'(out_valid), 64'd0);
        step();
        chk("t5_idle", 64'(busy), 64'd0);

        // Asynchronous reset mid-RUN
        go();
        send(32'h978, 56'h9);
        step();
        chk("t6_pre_valid", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 64'(out_valid), 64'd0);
        chk("t6_rst_busy", 64'(busy), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        go();
        send(32'h0000_0100, 56'hCD);
        send(32'h0000_0000, 56'hAB);
        step();
        pop_check("t6_mask_full", 32'h0, 56'hAB);
        chk("t6_empty", 64'(out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
